final_row_accumulator: RTL and testbench

- Downstream of the last processing element in the systolic array.
- Captures the (m_val, i_val) pair the last PE emits for each haplotype column and accumulates sum(m_val + i_val) over all columns in IEEE-754 double precision.
- Presents one likelihood per read/haplotype pair, tagged, through a valid/ready output handshake.
- Buffers incoming terms in a small FIFO because the double adder is multi-cycle. Back-pressures the array through stall.

---
 rtl/final_row_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_final_row_accumulator.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/final_row_accumulator.sv
// Final-row accumulator: sums m+i of the last PE per column in double
// precision and hands one tagged likelihood per read/haplotype pair out.
package final_row_pkg;
  typedef struct packed {
    logic [63:0] m_val;
    logic [63:0] i_val;
  } pe_calcs;
endpackage

module dp_adder_core #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] input_a,
  input  logic [63:0] input_b,
  input  logic        input_valid,
  output logic [63:0] output_z,
  output logic        output_done
);
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [7:0]  cnt;
  logic        busy;

  // Round-to-nearest-even add with G/R/S bits below the 53-bit significand.
  function automatic logic [63:0] fp_add(
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [63:0] x, y, z;
    logic        sa, sb, sz, sub, rnd;
    logic [10:0] ea, eb, xa, xb, d;
    logic [52:0] ma, mb;
    logic [55:0] fa_x, fb_x, fb_s, mask, m;
    logic [56:0] s;
    logic [12:0] e, sh;
    logic [6:0]  lz;
    logic [53:0] mant;
    if (b[62:0] > a[62:0]) begin
      x = b; y = a;
    end else begin
      x = a; y = b;
    end
    sa = x[63]; sb = y[63];
    ea = x[62:52]; eb = y[62:52];
    if (ea == 11'h7FF) begin
      if (x[51:0] != 52'd0 ||
          (eb == 11'h7FF && (y[51:0] != 52'd0 || sa != sb)))
        z = 64'h7FF8000000000000;
      else
        z = x;
    end else begin
      ma = {ea != 11'd0, x[51:0]};
      mb = {eb != 11'd0, y[51:0]};
      xa = (ea == 11'd0) ? 11'd1 : ea;
      xb = (eb == 11'd0) ? 11'd1 : eb;
      d = xa - xb;
      fa_x = {ma, 3'b000};
      fb_x = {mb, 3'b000};
      if (d >= 11'd56) begin
        fb_s = {55'd0, |mb};
      end else begin
        mask = (56'd1 << d) - 56'd1;
        fb_s = fb_x >> d;
        fb_s[0] = fb_s[0] | (|(fb_x & mask));
      end
      sub = sa ^ sb;
      if (sub) s = {1'b0, fa_x} - {1'b0, fb_s};
      else     s = {1'b0, fa_x} + {1'b0, fb_s};
      sz = (sub && s == 57'd0) ? 1'b0 : sa;
      e = {2'b00, xa};
      if (s[56]) begin
        m = s[56:1] | {55'd0, s[0]};
        e = e + 13'd1;
      end else begin
        lz = 7'd56;
        for (int i = 0; i < 56; i++)
          if (s[i]) lz = 7'(55 - i);
        sh = ({6'd0, lz} < e - 13'd1) ? {6'd0, lz} : e - 13'd1;
        m = s[55:0] << sh;
        e = e - sh;
      end
      rnd = m[2] & (m[1] | m[0] | m[3]);
      mant = {1'b0, m[55:3]} + {53'd0, rnd};
      if (mant[53]) begin
        mant = mant >> 1;
        e = e + 13'd1;
      end
      if (e >= 13'd2047)
        z = {sz, 11'h7FF, 52'd0};
      else
        z = {sz, mant[52] ? e[10:0] : 11'd0, mant[51:0]};
    end
    return z;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      output_z    <= '0;
      output_done <= 1'b0;
    end else if (input_valid) begin
      a_q         <= input_a;
      b_q         <= input_b;
      cnt         <= 8'(LAT - 1);
      busy        <= 1'b1;
      output_done <= 1'b0;
    end else if (busy) begin
      if (cnt == 8'd0) begin
        output_z    <= fp_add(a_q, b_q);
        output_done <= 1'b1;
        busy        <= 1'b0;
      end else begin
        cnt <= cnt - 8'd1;
      end
    end
  end
endmodule

module final_row_accumulator
  import final_row_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [63:0] ZERO       = 64'h0,
  parameter int          TAG_W      = 8,
  parameter int          ADD_LAT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  pe_calcs          pe_vals_in,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             global_stall,
  output logic             stall,
  output logic [63:0]      result,
  output logic [TAG_W-1:0] result_tag,
  output logic             result_valid,
  input  logic             result_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, POP, ADD_M, ADD_I, WAIT, OUT
  } state_t;

  state_t state, nxt;

  logic [63:0]   f_m [FIFO_DEPTH];
  logic [63:0]   f_i [FIFO_DEPTH];
  logic          f_l [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [TAG_W-1:0] tq [2];
  logic             tq_wr, tq_rd;
  logic [1:0]       tq_cnt;
  logic             in_pair;

  logic [63:0] acc, op_m, op_i, add_z;
  logic        op_last, issued, restart_q;
  logic        add_done, add_rst;
  logic        push, first_push, tag_pop;
  logic        pop, add_go, take, out_ack;

  // A new pair also waits while both pending tag slots are occupied.
  assign stall = global_stall || count == FULL ||
                 (!in_pair && tq_cnt == 2'd2);
  assign push       = in_valid && !stall;
  assign first_push = push && !in_pair;
  assign tag_pop    = take && state == ADD_I && op_last;
  assign add_rst    = ~reset | restart_q;

  dp_adder_core #(.LAT(ADD_LAT)) u_add (
    .clk         (clk),
    .reset       (add_rst),
    .input_a     (acc),
    .input_b     (state == ADD_I ? op_i : op_m),
    .input_valid (add_go),
    .output_z    (add_z),
    .output_done (add_done)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      f_m[wr_ptr] <= pe_vals_in.m_val;
      f_i[wr_ptr] <= pe_vals_in.i_val;
      f_l[wr_ptr] <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tq[0]   <= '0;
      tq[1]   <= '0;
      tq_wr   <= 1'b0;
      tq_rd   <= 1'b0;
      tq_cnt  <= 2'd0;
      in_pair <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        in_pair <= !in_last;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (first_push) begin
        tq[tq_wr] <= tag_in;
        tq_wr     <= ~tq_wr;
      end
      if (tag_pop) tq_rd <= ~tq_rd;
      if (first_push && !tag_pop)      tq_cnt <= tq_cnt + 2'd1;
      else if (tag_pop && !first_push) tq_cnt <= tq_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!global_stall) begin
      unique case (state)
        IDLE:  if (count != '0) nxt = POP;
        POP:   nxt = ADD_M;
        ADD_M: if (take) nxt = ADD_I;
        ADD_I: if (take)
                 nxt = op_last ? OUT :
                       (count != '0 ? POP : WAIT);
        WAIT:  if (count != '0) nxt = POP;
        OUT:   if (result_ready)
                 nxt = (count != '0) ? POP : IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    pop     = 1'b0;
    add_go  = 1'b0;
    take    = 1'b0;
    out_ack = 1'b0;
    if (!global_stall) begin
      unique case (state)
        POP: pop = 1'b1;
        ADD_M, ADD_I: begin
          add_go = !issued && !restart_q;
          take   = issued && add_done;
        end
        OUT: out_ack = result_ready;
        default: ;
      endcase
    end
  end

  // The adder is cleared the cycle after each result is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= ZERO;
      op_m         <= '0;
      op_i         <= '0;
      op_last      <= 1'b0;
      issued       <= 1'b0;
      restart_q    <= 1'b0;
      result       <= '0;
      result_tag   <= '0;
      result_valid <= 1'b0;
    end else begin
      restart_q <= take;
      if (add_go) issued <= 1'b1;
      if (take)   issued <= 1'b0;
      if (!global_stall && state == IDLE) acc <= ZERO;
      if (pop) begin
        op_m    <= f_m[rd_ptr];
        op_i    <= f_i[rd_ptr];
        op_last <= f_l[rd_ptr];
      end
      if (take) acc <= add_z;
      if (tag_pop) begin
        result       <= add_z;
        result_tag   <= tq[tq_rd];
        result_valid <= 1'b1;
      end
      if (out_ack) begin
        result_valid <= 1'b0;
        acc          <= ZERO;
      end
    end
  end
endmodule

// File: tb/tb_final_row_accumulator.sv
// Scoreboard bench for final_row_accumulator: random and directed pairs
// checked bit-exactly against a real-arithmetic reference sum.
module tb_final_row_accumulator;
  import final_row_pkg::*;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  pe_calcs       pe_vals_in;
  logic          in_valid, in_last;
  logic [TW-1:0] tag_in;
  logic          global_stall, stall;
  logic [63:0]   result;
  logic [TW-1:0] result_tag;
  logic          result_valid, result_ready;

  int checks = 0;
  int fails  = 0;
  int n_results = 0;
  int ready_mode = 0;
  int gs_mode = 0;
  logic saw_stall;

  typedef struct {
    logic [TW-1:0] tag;
    logic [63:0]   val;
  } exp_t;
  exp_t expq[$];
  logic [63:0] cur_m[$];
  logic [63:0] cur_i[$];

  always #5 clk = ~clk;

  final_row_accumulator #(
    .FIFO_DEPTH(4), .ZERO(64'h0), .TAG_W(TW), .ADD_LAT(6)
  ) dut (
    .clk(clk), .reset(reset), .pe_vals_in(pe_vals_in),
    .in_valid(in_valid), .in_last(in_last), .tag_in(tag_in),
    .global_stall(global_stall), .stall(stall),
    .result(result), .result_tag(result_tag),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic logic [63:0] ref_sum();
    real a;
    a = 0.0;
    for (int k = 0; k < cur_m.size(); k++) begin
      a = a + $bitstoreal(cur_m[k]);
      a = a + $bitstoreal(cur_i[k]);
    end
    return $realtobits(a);
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] r;
    r[63] = 1'($urandom_range(0, 1));
    r[62:52] = 11'(1015 + $urandom_range(0, 16));
    r[51:32] = 20'($urandom);
    r[31:0] = $urandom;
    if ($urandom_range(0, 9) == 0) r = 64'h0;
    return r;
  endfunction

  task automatic push_col(logic [63:0] m, logic [63:0] i,
                          logic last, logic [TW-1:0] tg);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    pe_vals_in.m_val = m;
    pe_vals_in.i_val = i;
    in_last = last;
    tag_in = tg;
    #1;
    while (stall && guard < 3000) begin
      saw_stall = 1'b1;
      guard++;
      @(negedge clk);
      #1;
    end
    if (stall) begin
      checks++;
      fails++;
      $display("FAIL push_timeout: stall still 1, want 0");
    end
    @(posedge clk);
  endtask

  task automatic push_pair(logic [TW-1:0] tg, logic have_exp,
                           logic [63:0] exp_val);
    exp_t e;
    e.tag = tg;
    e.val = have_exp ? exp_val : ref_sum();
    expq.push_back(e);
    for (int k = 0; k < cur_m.size(); k++)
      push_col(cur_m[k], cur_i[k], k == cur_m.size() - 1, tg);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_valid(string nm);
    int n = 0;
    while (!result_valid && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(nm, {63'd0, result_valid}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: result_ready = 1'b1;
        1: result_ready = 1'b0;
        default: result_ready = 1'($urandom_range(0, 1));
      endcase
      if (gs_mode == 0) global_stall = 1'b0;
      else if (gs_mode == 1)
        global_stall = ($urandom_range(0, 9) == 0);
    end
  end

  initial begin
    logic          held_v;
    logic [63:0]   held_r;
    logic [TW-1:0] held_t;
    exp_t          e;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        held_v = 1'b0;
      end else if (result_valid) begin
        if (held_v) begin
          chk("hold_result", result, held_r);
          chk("hold_tag", 64'(result_tag), 64'(held_t));
        end
        if (result_ready && !global_stall) begin
          if (expq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL extra_result: got %h want none", result);
          end else begin
            e = expq.pop_front();
            chk("result", result, e.val);
            chk("result_tag", 64'(result_tag), 64'(e.tag));
          end
          n_results++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_r = result;
          held_t = result_tag;
        end
      end else if (held_v) begin
        chk("valid_dropped", 64'(result_valid), 64'd1);
        held_v = 1'b0;
      end
    end
  end

  initial begin
    int nres;
    reset = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    tag_in = '0;
    pe_vals_in = '0;
    global_stall = 1'b0;
    result_ready = 1'b0;
    gs_mode = 2;
    #1;
    chk("rst_result", result, 64'h0);
    chk("rst_tag", 64'(result_tag), 64'h0);
    chk("rst_valid", 64'(result_valid), 64'h0);
    chk("rst_stall_lo", 64'(stall), 64'h0);
    global_stall = 1'b1;
    #1;
    chk("rst_stall_hi", 64'(stall), 64'h1);
    global_stall = 1'b0;
    gs_mode = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    ready_mode = 1;
    cur_m = {64'h3FE0000000000000, 64'h3FC0000000000000, 64'h0};
    cur_i = {64'h3FD0000000000000, 64'h3FC0000000000000,
             64'h3FF0000000000000};
    push_pair(8'h3A, 1'b1, 64'h4000000000000000);
    wait_valid("t1_valid");
    repeat (10) @(negedge clk);
    ready_mode = 0;
    drain();

    saw_stall = 1'b0;
    cur_m.delete();
    cur_i.delete();
    for (int k = 0; k < 6; k++) begin
      cur_m.push_back(rand_dbl());
      cur_i.push_back(rand_dbl());
    end
    push_pair(8'h42, 1'b0, 64'h0);
    chk("t2_stall_seen", 64'(saw_stall), 64'h1);
    drain();

    ready_mode = 1;
    cur_m = {rand_dbl(), rand_dbl()};
    cur_i = {rand_dbl(), rand_dbl()};
    push_pair(8'h01, 1'b0, 64'h0);
    wait_valid("t3_valid");
    cur_m = {64'h3FF0000000000000};
    cur_i = {64'h0};
    push_pair(8'h05, 1'b1, 64'h3FF0000000000000);
    repeat (20) @(negedge clk);
    ready_mode = 0;
    drain();

    gs_mode = 2;
    cur_m = {rand_dbl()};
    cur_i = {rand_dbl()};
    push_pair(8'h77, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      global_stall = 1'b1;
      #1;
      chk("t4_stall", 64'(stall), 64'h1);
      @(negedge clk);
    end
    global_stall = 1'b0;
    gs_mode = 0;
    drain();

    nres = n_results;
    cur_m = {64'h0};
    cur_i = {64'h0};
    push_pair(8'h66, 1'b1, 64'h0);
    drain();
    repeat (20) @(negedge clk);
    chk("t6_once", 64'(n_results - nres), 64'd1);

    ready_mode = 1;
    cur_m = {rand_dbl()};
    cur_i = {rand_dbl()};
    push_pair(8'h11, 1'b0, 64'h0);
    wait_valid("t5_valid");
    push_col(rand_dbl(), rand_dbl(), 1'b0, 8'h12);
    push_col(rand_dbl(), rand_dbl(), 1'b0, 8'h12);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    reset = 1'b0;
    expq.delete();
    #1;
    chk("t5_rst_result", result, 64'h0);
    chk("t5_rst_valid", 64'(result_valid), 64'h0);
    chk("t5_rst_tag", 64'(result_tag), 64'h0);
    chk("t5_rst_stall", 64'(stall), 64'(global_stall));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ready_mode = 0;
    cur_m = {64'h3FE0000000000000};
    cur_i = {64'h3FE0000000000000};
    push_pair(8'h22, 1'b1, 64'h3FF0000000000000);
    drain();

    ready_mode = 2;
    gs_mode = 1;
    for (int p = 0; p < 15; p++) begin
      int n;
      n = $urandom_range(1, 6);
      cur_m.delete();
      cur_i.delete();
      for (int k = 0; k < n; k++) begin
        cur_m.push_back(rand_dbl());
        cur_i.push_back(rand_dbl());
      end
      push_pair(8'(p + 100), 1'b0, 64'h0);
    end
    drain();
    gs_mode = 0;
    ready_mode = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
